frame_scanout: RTL and testbench

FRAME_SCANOUT -- requirements
Module: frame_scanout

---
 rtl/display_pkg.sv | 29 ++
 rtl/vga_timing.sv | 56 +++++
 rtl/frame_scanout.sv | 182 ++++++++++++++++++
 tb/tb_frame_scanout.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - VGA 640x480@60 timing constants, RGB444 pixel type and swap FSM states
package display_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int CNT_W = 10;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef enum logic {
    ST_SCAN = 1'b0,
    ST_ACK  = 1'b1
  } swap_state_t;

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - Pixel/line counters with raw (undelayed) active flag and active-low syncs
module vga_timing
  import display_pkg::*;
#(
  parameter int T_H_ACTIVE = H_ACTIVE,
  parameter int T_H_FP     = H_FP,
  parameter int T_H_SYNC   = H_SYNC,
  parameter int T_H_TOTAL  = H_TOTAL,
  parameter int T_V_ACTIVE = V_ACTIVE,
  parameter int T_V_FP     = V_FP,
  parameter int T_V_SYNC   = V_SYNC,
  parameter int T_V_TOTAL  = V_TOTAL
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pix_ce,
  output logic [CNT_W-1:0] o_h,
  output logic [CNT_W-1:0] o_v,
  output logic             o_active,
  output logic             o_hsync,
  output logic             o_vsync
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(T_H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(T_V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(T_H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(T_V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_ON  = CNT_W'(T_H_ACTIVE + T_H_FP);
  localparam logic [CNT_W-1:0] HS_OFF = CNT_W'(T_H_ACTIVE + T_H_FP + T_H_SYNC);
  localparam logic [CNT_W-1:0] VS_ON  = CNT_W'(T_V_ACTIVE + T_V_FP);
  localparam logic [CNT_W-1:0] VS_OFF = CNT_W'(T_V_ACTIVE + T_V_FP + T_V_SYNC);

  logic [CNT_W-1:0] r_h;
  logic [CNT_W-1:0] r_v;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (i_pix_ce) begin
      if (r_h == H_LAST) begin
        r_h <= '0;
        r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
      end else begin
        r_h <= r_h + 1'b1;
      end
    end
  end

  assign o_h      = r_h;
  assign o_v      = r_v;
  assign o_active = (r_h < H_ACT) && (r_v < V_ACT);
  assign o_hsync  = !((r_h >= HS_ON) && (r_h < HS_OFF));
  assign o_vsync  = !((r_v >= VS_ON) && (r_v < VS_OFF));

endmodule

// File: rtl/frame_scanout.sv
// rtl/frame_scanout.sv - Double-buffered framebuffer scanout with vblank buffer-swap handshake
// Define FRAME_SCANOUT_BORDER_EN to force a white 1-pixel border on the active-area perimeter.
module frame_scanout
  import display_pkg::*;
#(
  parameter int BUFFER_WIDTH      = 160,
  parameter int BUFFER_HEIGHT     = 120,
  parameter int BUFFER_DATA_WIDTH = 12,
  parameter int BUFFER_ADDR_WIDTH = $clog2(BUFFER_WIDTH * BUFFER_HEIGHT),
  parameter int SCALE             = 4,
  parameter int T_H_ACTIVE        = H_ACTIVE,
  parameter int T_H_FP            = H_FP,
  parameter int T_H_SYNC          = H_SYNC,
  parameter int T_H_TOTAL         = H_TOTAL,
  parameter int T_V_ACTIVE        = V_ACTIVE,
  parameter int T_V_FP            = V_FP,
  parameter int T_V_SYNC          = V_SYNC,
  parameter int T_V_TOTAL         = V_TOTAL
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pix_ce,
  input  logic                         frame_done,
  output logic                         draw_ack,
  output logic                         buffer_select,
  output logic                         read_en,
  output logic [BUFFER_ADDR_WIDTH-1:0] read_addr,
  input  logic [BUFFER_DATA_WIDTH-1:0] read_data,
  output logic                         hsync,
  output logic                         vsync,
  output logic [3:0]                   vga_r,
  output logic [3:0]                   vga_g,
  output logic [3:0]                   vga_b
);

  localparam logic [CNT_W-1:0] V_BLANK = CNT_W'(T_V_ACTIVE);

  logic [CNT_W-1:0] w_h;
  logic [CNT_W-1:0] w_v;
  logic             w_active;
  logic             w_hsync_raw;
  logic             w_vsync_raw;

  vga_timing #(
    .T_H_ACTIVE(T_H_ACTIVE),
    .T_H_FP    (T_H_FP),
    .T_H_SYNC  (T_H_SYNC),
    .T_H_TOTAL (T_H_TOTAL),
    .T_V_ACTIVE(T_V_ACTIVE),
    .T_V_FP    (T_V_FP),
    .T_V_SYNC  (T_V_SYNC),
    .T_V_TOTAL (T_V_TOTAL)
  ) u_timing (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_pix_ce(pix_ce),
    .o_h     (w_h),
    .o_v     (w_v),
    .o_active(w_active),
    .o_hsync (w_hsync_raw),
    .o_vsync (w_vsync_raw)
  );

  assign read_en   = w_active;
  assign read_addr = BUFFER_ADDR_WIDTH'((32'(w_v) / SCALE) * BUFFER_WIDTH + 32'(w_h) / SCALE);

  // RAM data only lands one clk after the address; with a slow pix_ce we hold that
  // sample so the colour stage sees the same pixel regardless of the pix_ce rate.
  logic                         r_ce_d;
  logic [BUFFER_DATA_WIDTH-1:0] r_hold;
  logic [BUFFER_DATA_WIDTH-1:0] w_pix;
  logic [BUFFER_DATA_WIDTH-1:0] w_src;

  assign w_pix = r_ce_d ? read_data : r_hold;

`ifdef FRAME_SCANOUT_BORDER_EN
  localparam logic [CNT_W-1:0] H_EDGE = CNT_W'(T_H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_EDGE = CNT_W'(T_V_ACTIVE - 1);

  logic w_edge;
  logic r_b1;

  assign w_edge = (w_h == '0) || (w_h == H_EDGE) || (w_v == '0) || (w_v == V_EDGE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_b1 <= 1'b0;
    end else if (pix_ce) begin
      r_b1 <= w_edge;
    end
  end

  assign w_src = r_b1 ? '1 : w_pix;
`else
  assign w_src = w_pix;
`endif

  logic    r_a1;
  logic    r_a2;
  logic    r_hs1;
  logic    r_hs2;
  logic    r_vs1;
  logic    r_vs2;
  rgb444_t r_colour;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ce_d   <= 1'b0;
      r_hold   <= '0;
      r_a1     <= 1'b0;
      r_a2     <= 1'b0;
      r_hs1    <= 1'b1;
      r_hs2    <= 1'b1;
      r_vs1    <= 1'b1;
      r_vs2    <= 1'b1;
      r_colour <= '0;
    end else begin
      r_ce_d <= pix_ce;
      r_hold <= w_pix;
      if (pix_ce) begin
        r_a1     <= w_active;
        r_a2     <= r_a1;
        r_hs1    <= w_hsync_raw;
        r_hs2    <= r_hs1;
        r_vs1    <= w_vsync_raw;
        r_vs2    <= r_vs1;
        r_colour <= r_a1 ? rgb444_t'(w_src) : '0;
      end
    end
  end

  rgb444_t w_out;

  assign w_out = r_a2 ? r_colour : '0;
  assign hsync = r_hs2;
  assign vsync = r_vs2;
  assign vga_r = w_out.r;
  assign vga_g = w_out.g;
  assign vga_b = w_out.b;

  // Swap only at the first pix_ce of vblank, so the visible frame never tears.
  swap_state_t r_state;
  swap_state_t w_next_state;
  logic        w_swap;
  logic        w_vblank_start;
  logic        r_draw_ack;
  logic        r_buf;

  assign w_vblank_start = (w_h == '0) && (w_v == V_BLANK);

  always_comb begin
    w_next_state = r_state;
    w_swap       = 1'b0;
    case (r_state)
      ST_SCAN: begin
        if (pix_ce && w_vblank_start && frame_done) begin
          w_swap       = 1'b1;
          w_next_state = ST_ACK;
        end
      end
      ST_ACK: begin
        w_next_state = ST_SCAN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_SCAN;
      r_draw_ack <= 1'b0;
      r_buf      <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_draw_ack <= w_swap;
      r_buf      <= r_buf ^ w_swap;
    end
  end

  assign draw_ack      = r_draw_ack;
  assign buffer_select = r_buf;

endmodule

// File: tb/tb_frame_scanout.sv
// tb/tb_frame_scanout.sv - Bench for frame_scanout: full-size VGA instance plus a shrunken-geometry instance
module tb_frame_scanout;

  localparam int FHA = 640, FHF = 16, FHS = 96, FHT = 800;
  localparam int FVA = 480, FVF = 10, FVS = 2,  FVT = 525;
  localparam int SHA = 16,  SHF = 2,  SHS = 3,  SHT = 24;
  localparam int SVA = 12,  SVF = 2,  SVS = 2,  SVT = 18;
  localparam int SBW = 4, SBH = 3, SSC = 4;
  localparam int SFT = SHT * SVT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_ce = 1'b0;
  logic frame_done = 1'b0;

  always #5 clk = ~clk;

  logic        f_ack, f_buf, f_ren, f_hs, f_vs;
  logic [14:0] f_addr;
  logic [11:0] f_rdata;
  logic [3:0]  f_r, f_g, f_b;

  logic        s_ack, s_buf, s_ren, s_hs, s_vs;
  logic [3:0]  s_addr;
  logic [11:0] s_rdata;
  logic [3:0]  s_r, s_g, s_b;

  logic [11:0] ram_s [0:SBW*SBH-1];

  always @(posedge clk) begin
    if (f_ren) f_rdata <= f_addr[11:0];
    if (s_ren) s_rdata <= ram_s[s_addr];
  end

  frame_scanout u_full (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .frame_done(frame_done),
    .draw_ack(f_ack), .buffer_select(f_buf), .read_en(f_ren), .read_addr(f_addr),
    .read_data(f_rdata), .hsync(f_hs), .vsync(f_vs), .vga_r(f_r), .vga_g(f_g), .vga_b(f_b)
  );

  frame_scanout #(
    .BUFFER_WIDTH(SBW), .BUFFER_HEIGHT(SBH), .SCALE(SSC),
    .T_H_ACTIVE(SHA), .T_H_FP(SHF), .T_H_SYNC(SHS), .T_H_TOTAL(SHT),
    .T_V_ACTIVE(SVA), .T_V_FP(SVF), .T_V_SYNC(SVS), .T_V_TOTAL(SVT)
  ) u_small (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .frame_done(frame_done),
    .draw_ack(s_ack), .buffer_select(s_buf), .read_en(s_ren), .read_addr(s_addr),
    .read_data(s_rdata), .hsync(s_hs), .vsync(s_vs), .vga_r(s_r), .vga_g(s_g), .vga_b(s_b)
  );

  int   total = 0;
  int   bad = 0;
  int   n = 0;
  logic exp_buf = 1'b0;
  logic exp_ack = 1'b0;

  // Video seen at the pins after cnt pix_ce strobes since reset: {hsync, vsync, rgb}.
  function automatic logic [13:0] exp_vid(input int cnt, input bit full);
    int ha, hf, hs, ht, va, vf, vs, vt, bw, q, h, v, a;
    logic [11:0] rgb;
    logic hsv, vsv;
    if (full) begin
      ha = FHA; hf = FHF; hs = FHS; ht = FHT; va = FVA; vf = FVF; vs = FVS; vt = FVT; bw = 160;
    end else begin
      ha = SHA; hf = SHF; hs = SHS; ht = SHT; va = SVA; vf = SVF; vs = SVS; vt = SVT; bw = SBW;
    end
    if (cnt < 2) return {2'b11, 12'h000};
    q = cnt - 2;
    h = q % ht;
    v = (q / ht) % vt;
    hsv = !(h >= ha + hf && h < ha + hf + hs);
    vsv = !(v >= va + vf && v < va + vf + vs);
    a = (v / SSC) * bw + h / SSC;
    rgb = 12'h000;
    if (h < ha && v < va) begin
      rgb = full ? a[11:0] : ram_s[a];
`ifdef FRAME_SCANOUT_BORDER_EN
      if (h == 0 || h == ha - 1 || v == 0 || v == va - 1) rgb = 12'hFFF;
`endif
    end
    return {hsv, vsv, rgb};
  endfunction

  // Read strobe/address for the counter position after cnt strobes: {read_en, addr}.
  function automatic logic [15:0] exp_rd(input int cnt, input bit full);
    int ha, ht, va, vt, bw, h, v, a;
    if (full) begin
      ha = FHA; ht = FHT; va = FVA; vt = FVT; bw = 160;
    end else begin
      ha = SHA; ht = SHT; va = SVA; vt = SVT; bw = SBW;
    end
    h = cnt % ht;
    v = (cnt / ht) % vt;
    a = (v / SSC) * bw + h / SSC;
    return {(h < ha && v < va), 15'(a)};
  endfunction

  task automatic step(input logic ce);
    int h, v;
    pix_ce = ce;
    @(posedge clk);
    if (rst) begin
      n = 0;
      exp_buf = 1'b0;
      exp_ack = 1'b0;
    end else begin
      h = n % SHT;
      v = (n / SHT) % SVT;
      exp_ack = ce && frame_done && h == 0 && v == SVA;
      if (exp_ack) exp_buf = ~exp_buf;
      if (ce) n = n + 1;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    frame_done = 1'b0;
    step(1'b1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b1);
    step(1'b0);
    total++; if ({s_hs, s_vs} !== 2'b11) begin bad++; $display("FAIL reset_small_sync got=%b exp=11", {s_hs, s_vs}); end
    total++; if ({s_r, s_g, s_b} !== 12'h000) begin bad++; $display("FAIL reset_small_rgb got=%h exp=000", {s_r, s_g, s_b}); end
    total++; if ({s_ack, s_buf} !== 2'b00) begin bad++; $display("FAIL reset_small_ack_buf got=%b exp=00", {s_ack, s_buf}); end
    total++; if ({s_ren, s_addr} !== 5'b10000) begin bad++; $display("FAIL reset_small_read got=%b exp=10000", {s_ren, s_addr}); end
    total++; if ({f_hs, f_vs, f_r, f_g, f_b} !== 14'h3000) begin bad++; $display("FAIL reset_full_video got=%h exp=3000", {f_hs, f_vs, f_r, f_g, f_b}); end
    total++; if ({f_ren, f_addr} !== 16'h8000) begin bad++; $display("FAIL reset_full_read got=%h exp=8000", {f_ren, f_addr}); end
    rst = 1'b0;
  endtask

  task automatic test_hsync_period();
    int t_fall1 = -1, t_fall2 = -1, t_rise = -1, n_fall1 = -1;
    logic prev;
    prev = f_hs;
    for (int c = 0; c < 2000 && t_fall2 < 0; c++) begin
      step(1'b1);
      if (prev && !f_hs) begin
        if (t_fall1 < 0) begin t_fall1 = c; n_fall1 = n; end
        else t_fall2 = c;
      end
      if (!prev && f_hs && t_fall1 >= 0 && t_rise < 0) t_rise = c;
      prev = f_hs;
    end
    total++; if (n_fall1 !== FHA + FHF + 2) begin bad++; $display("FAIL hsync_first_fall got=%0d exp=%0d", n_fall1, FHA + FHF + 2); end
    total++; if (t_fall2 - t_fall1 !== FHT) begin bad++; $display("FAIL hsync_period got=%0d exp=%0d", t_fall2 - t_fall1, FHT); end
    total++; if (t_rise - t_fall1 !== FHS) begin bad++; $display("FAIL hsync_low got=%0d exp=%0d", t_rise - t_fall1, FHS); end
  endtask

  task automatic test_pixel_fetch();
    int errs = 0;
    for (int c = 0; c < 8000 && n != 9 * FHT + 5; c++) begin
      step(1'b1);
      if ({f_hs, f_vs, f_r, f_g, f_b} !== exp_vid(n, 1'b1)) errs++;
      if ({f_ren, f_addr} !== exp_rd(n, 1'b1)) errs++;
    end
    total++; if (n !== 9 * FHT + 5) begin bad++; $display("FAIL fetch_reach got=%0d exp=%0d", n, 9 * FHT + 5); end
    total++; if ({f_ren, f_addr} !== {1'b1, 15'd321}) begin bad++; $display("FAIL fetch_addr got=%0d/%0d exp=1/321", f_ren, f_addr); end
    step(1'b1);
    step(1'b1);
    total++; if ({f_r, f_g, f_b} !== 12'd321) begin bad++; $display("FAIL fetch_rgb got=%h exp=%h", {f_r, f_g, f_b}, 12'd321); end
    total++; if (errs !== 0) begin bad++; $display("FAIL full_trace errs got=%0d exp=0", errs); end
  endtask

  task automatic test_random_scan();
    int verr = 0, rerr = 0, aerr = 0;
    logic [15:0] rd;
    for (int i = 0; i < SBW * SBH; i++) ram_s[i] = 12'($urandom);
    do_reset();
    for (int c = 0; c < 4 * SFT; c++) begin
      step(1'($urandom_range(0, 1)));
      rd = exp_rd(n, 1'b0);
      if ({s_hs, s_vs, s_r, s_g, s_b} !== exp_vid(n, 1'b0)) verr++;
      if (s_ren !== rd[15] || (rd[15] && s_addr !== rd[3:0])) rerr++;
      if ({s_ack, s_buf} !== 2'b00) aerr++;
    end
    total++; if (verr !== 0) begin bad++; $display("FAIL random_video errs got=%0d exp=0", verr); end
    total++; if (rerr !== 0) begin bad++; $display("FAIL random_read errs got=%0d exp=0", rerr); end
    total++; if (aerr !== 0) begin bad++; $display("FAIL random_no_swap errs got=%0d exp=0", aerr); end
  endtask

  task automatic test_swap_held();
    int errs = 0, acks = 0, n_ack = -1, since = -1, width = 0, maxw = 0;
    do_reset();
    for (int c = 0; c < 3 * SFT; c++) begin
      if (n == 5 * SHT && acks == 0) frame_done = 1'b1;
      step(1'b1);
      if ({s_ack, s_buf} !== {exp_ack, exp_buf}) errs++;
      if ({s_hs, s_vs, s_r, s_g, s_b} !== exp_vid(n, 1'b0)) errs++;
      if (s_ack) begin
        acks++; width++;
        if (n_ack < 0) begin n_ack = n; since = 0; end
      end else width = 0;
      if (width > maxw) maxw = width;
      if (since >= 0) begin
        since++;
        if (since == 3) frame_done = 1'b0;
      end
    end
    total++; if (acks !== 1) begin bad++; $display("FAIL held_ack_count got=%0d exp=1", acks); end
    total++; if (maxw !== 1) begin bad++; $display("FAIL held_ack_width got=%0d exp=1", maxw); end
    total++; if (n_ack !== SVA * SHT + 1) begin bad++; $display("FAIL held_swap_point got=%0d exp=%0d", n_ack, SVA * SHT + 1); end
    total++; if (s_buf !== 1'b1) begin bad++; $display("FAIL held_buf_final got=%b exp=1", s_buf); end
    total++; if (errs !== 0) begin bad++; $display("FAIL held_trace errs got=%0d exp=0", errs); end
  endtask

  task automatic test_reset_mid();
    int errs = 0, c = 0;
    logic [15:0] rd;
    while (c < 4 * SFT && !((n % SFT) == 6 * SHT + 10)) begin
      step(1'(c % 4 == 0));
      if ({s_hs, s_vs, s_r, s_g, s_b} !== exp_vid(n, 1'b0)) errs++;
      c++;
    end
    total++; if ((n % SFT) !== 6 * SHT + 10) begin bad++; $display("FAIL midrst_reach got=%0d exp=%0d", n % SFT, 6 * SHT + 10); end
    rst = 1'b1;
    frame_done = 1'b1;
    step(1'b0);
    rst = 1'b0;
    total++; if ({s_hs, s_vs, s_r, s_g, s_b} !== 14'h3000) begin bad++; $display("FAIL midrst_video got=%h exp=3000", {s_hs, s_vs, s_r, s_g, s_b}); end
    total++; if ({s_ren, s_addr, s_ack, s_buf} !== 7'b1000000) begin bad++; $display("FAIL midrst_state got=%b exp=1000000", {s_ren, s_addr, s_ack, s_buf}); end
    frame_done = 1'b0;
    for (int k = 0; k < 800; k++) begin
      step(1'(k % 4 == 0));
      rd = exp_rd(n, 1'b0);
      if ({s_hs, s_vs, s_r, s_g, s_b} !== exp_vid(n, 1'b0)) errs++;
      if (s_ren !== rd[15] || (rd[15] && s_addr !== rd[3:0]) || s_ack !== 1'b0) errs++;
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL midrst_trace errs got=%0d exp=0", errs); end
  endtask

  task automatic test_swap_edges();
    int late_n, n_ack = -1;
    do_reset();
    for (int c = 0; c < 2 * SFT && (n % SFT) != SVA * SHT; c++) step(1'b1);
    frame_done = 1'b1;
    step(1'b1);
    total++; if ({s_ack, s_buf} !== 2'b11) begin bad++; $display("FAIL same_clk_swap got=%b exp=11", {s_ack, s_buf}); end
    frame_done = 1'b0;
    for (int k = 0; k < 5; k++) step(1'b1);
    for (int c = 0; c < 2 * SFT && (n % SFT) != SVA * SHT + 1; c++) step(1'b1);
    late_n = n;
    frame_done = 1'b1;
    step(1'b1);
    total++; if ({s_ack, s_buf} !== 2'b01) begin bad++; $display("FAIL late_no_swap got=%b exp=01", {s_ack, s_buf}); end
    for (int c = 0; c < SFT + 5 && n_ack < 0; c++) begin
      step(1'b1);
      if (s_ack) n_ack = n;
    end
    frame_done = 1'b0;
    total++; if (n_ack !== late_n + SFT) begin bad++; $display("FAIL late_deferred_swap got=%0d exp=%0d", n_ack, late_n + SFT); end
    total++; if (s_buf !== 1'b0) begin bad++; $display("FAIL late_buf got=%b exp=0", s_buf); end
  endtask

  initial begin
    test_reset();
    test_hsync_period();
    test_pixel_fetch();
    test_random_scan();
    test_swap_held();
    test_reset_mid();
    test_swap_edges();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
